// File: rtl/alu_pkg.sv
// Shared ALU definitions: control width, op-codes, MISR defaults and monitor states.
package alu_pkg;

    localparam int unsigned ALU_CTRL_W = 4;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_CTRL_W-1:0] ALU_NOR = 4'b1100;

    localparam logic [31:0] MISR_POLY_DEF = 32'h04C11DB7;
    localparam logic [31:0] MISR_SEED_DEF = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } monState_t;

endpackage

// File: rtl/misr_reg.sv
// Multiple-input signature register: Galois-style shift with polynomial feedback.
module misr_reg #(
    parameter int unsigned WIDTH = 32,
    parameter logic [31:0] POLY  = 32'h04C11DB7,
    parameter logic [31:0] SEED  = 32'hFFFFFFFF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] POLY_W = WIDTH'(POLY);
    localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED);

    logic [WIDTH-1:0] feedback;

    assign feedback = q[WIDTH-1] ? POLY_W : '0;

    always_ff @(posedge clk) begin
        if (reset || load) begin
            q <= SEED_W;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], 1'b0} ^ feedback ^ din;
        end
    end

endmodule

// File: rtl/alu_result_monitor.sv
// Captures ALU results into a MISR signature and counts samples, zero and overflow events.
module alu_result_monitor
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_W     = 16,
    parameter logic [31:0] MISR_POLY = MISR_POLY_DEF,
    parameter logic [31:0] MISR_SEED = MISR_SEED_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic [CNT_W-1:0]      sampleLimit,
    input  logic                  sampleValid,
    input  logic [ALU_CTRL_W-1:0] aluControl,
    input  logic [WIDTH-1:0]      aluOut,
    input  logic                  zeroFlag,
    input  logic                  overflow,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      signature,
    output logic [CNT_W-1:0]      sampleCount,
    output logic [CNT_W-1:0]      zeroCount,
    output logic [CNT_W-1:0]      overflowCount
);

    localparam int unsigned FLAG_W = ALU_CTRL_W + 2;

    monState_t        state;
    monState_t        nextState;
    logic             enterRun;
    logic             absorb;
    logic [CNT_W-1:0] limitReg;
    logic [CNT_W-1:0] sampleCountInc;
    logic [WIDTH-1:0] misrDin;

    // Saturating next value of the sample counter, used for both update and limit compare.
    assign sampleCountInc = (sampleCount == '1) ? sampleCount : sampleCount + CNT_W'(1);

    assign misrDin = aluOut ^ WIDTH'({aluControl, overflow, zeroFlag});

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= nextState;
            busy  <= (nextState == RUN);
            done  <= (nextState == DONE);
        end
    end

    always_comb begin
        nextState = state;
        enterRun  = 1'b0;
        absorb    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    nextState = RUN;
                    enterRun  = 1'b1;
                end
            end
            RUN: begin
                absorb = sampleValid;
                if (stop || (sampleValid && (limitReg != '0) && (sampleCountInc == limitReg))) begin
                    nextState = DONE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Event counters saturate at all-ones; limit is captured as a run begins.
    always_ff @(posedge clk) begin
        if (reset) begin
            sampleCount   <= '0;
            zeroCount     <= '0;
            overflowCount <= '0;
            limitReg      <= '0;
        end else if (enterRun) begin
            sampleCount   <= '0;
            zeroCount     <= '0;
            overflowCount <= '0;
            limitReg      <= sampleLimit;
        end else if (absorb) begin
            sampleCount <= sampleCountInc;
            if (zeroFlag && (zeroCount != '1)) begin
                zeroCount <= zeroCount + CNT_W'(1);
            end
            if (overflow && (overflowCount != '1)) begin
                overflowCount <= overflowCount + CNT_W'(1);
            end
        end
    end

    misr_reg #(
        .WIDTH (WIDTH),
        .POLY  (MISR_POLY),
        .SEED  (MISR_SEED)
    ) uMisr (
        .clk   (clk),
        .reset (reset),
        .load  (enterRun),
        .shift (absorb),
        .din   (misrDin),
        .q     (signature)
    );

    initial begin : paramCheck
    end

endmodule

// File: tb/tb_alu_result_monitor.sv
// Self-checking bench: directed vector table, hand sequences and randomized model comparison.
module tb_alu_result_monitor;

    localparam logic [31:0] POLY = 32'h04C11DB7;

    logic        clk = 1'b0;
    logic        reset, start, stop, sampleValid, zeroFlag, overflow;
    logic [15:0] sampleLimit;
    logic [3:0]  aluControl;
    logic [31:0] aluOut;

    logic        busyA, doneA, busyB, doneB;
    logic [31:0] sigA, sigB;
    logic [15:0] scA, zcA, ocA;
    logic [3:0]  scB, zcB, ocB;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_result_monitor #(.WIDTH(32), .CNT_W(16), .MISR_POLY(POLY), .MISR_SEED(32'h0)) dutA (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .sampleLimit(sampleLimit),
        .sampleValid(sampleValid), .aluControl(aluControl), .aluOut(aluOut),
        .zeroFlag(zeroFlag), .overflow(overflow), .busy(busyA), .done(doneA),
        .signature(sigA), .sampleCount(scA), .zeroCount(zcA), .overflowCount(ocA));

    alu_result_monitor #(.WIDTH(32), .CNT_W(4)) dutB (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .sampleLimit(sampleLimit[3:0]),
        .sampleValid(sampleValid), .aluControl(aluControl), .aluOut(aluOut),
        .zeroFlag(zeroFlag), .overflow(overflow), .busy(busyB), .done(doneB),
        .signature(sigB), .sampleCount(scB), .zeroCount(zcB), .overflowCount(ocB));

    // Reference model: st 0=idle 1=run 2=done
    typedef struct {
        int          st;
        logic [31:0] sig;
        int unsigned sc, zc, oc, lim;
    } mdl_t;

    mdl_t mA, mB;

    typedef struct {
        logic        st, sp;
        logic [15:0] lim;
        logic        v;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic        z, ov;
        logic        eb, ed;
        logic [31:0] es;
        logic [15:0] esc, ezc, eoc;
    } vec_t;

    vec_t tbl[16];

    function automatic mdl_t mstep(mdl_t m, logic [31:0] seed, int unsigned cmax);
        logic [31:0] d;
        if (reset) begin
            m.st = 0; m.sig = seed; m.sc = 0; m.zc = 0; m.oc = 0; m.lim = 0;
            return m;
        end
        if (m.st != 1) begin
            if (start) begin
                m.st = 1; m.sig = seed; m.sc = 0; m.zc = 0; m.oc = 0;
                m.lim = 32'(sampleLimit) & cmax;
            end
        end else begin
            if (sampleValid) begin
                d = aluOut ^ {26'b0, aluControl, overflow, zeroFlag};
                m.sig = {m.sig[30:0], 1'b0} ^ (m.sig[31] ? POLY : 32'h0) ^ d;
                if (m.sc < cmax) m.sc++;
                if (zeroFlag && m.zc < cmax) m.zc++;
                if (overflow && m.oc < cmax) m.oc++;
            end
            if (stop || (sampleValid && m.lim != 0 && m.sc == m.lim)) m.st = 2;
        end
        return m;
    endfunction

    function automatic vec_t mk(logic st, logic sp, logic [15:0] lim, logic v, logic [3:0] ctrl,
                                logic [31:0] a, logic z, logic ov, logic eb, logic ed,
                                logic [31:0] es, logic [15:0] esc, logic [15:0] ezc,
                                logic [15:0] eoc);
        vec_t r;
        r.st = st; r.sp = sp; r.lim = lim; r.v = v; r.ctrl = ctrl; r.a = a; r.z = z; r.ov = ov;
        r.eb = eb; r.ed = ed; r.es = es; r.esc = esc; r.ezc = ezc; r.eoc = eoc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        mA = mstep(mA, 32'h0, 32'd65535);
        mB = mstep(mB, 32'hFFFFFFFF, 32'd15);
    endtask

    task automatic checkModel();
        chk("A.busy", 32'(busyA), 32'(mA.st == 1));
        chk("A.done", 32'(doneA), 32'(mA.st == 2));
        chk("A.sig",  sigA, mA.sig);
        chk("A.sc",   32'(scA), mA.sc);
        chk("A.zc",   32'(zcA), mA.zc);
        chk("A.oc",   32'(ocA), mA.oc);
        chk("B.busy", 32'(busyB), 32'(mB.st == 1));
        chk("B.done", 32'(doneB), 32'(mB.st == 2));
        chk("B.sig",  sigB, mB.sig);
        chk("B.sc",   32'(scB), mB.sc);
        chk("B.zc",   32'(zcB), mB.zc);
        chk("B.oc",   32'(ocB), mB.oc);
    endtask

    task automatic idleInputs();
        start = 0; stop = 0; sampleValid = 0; aluControl = 0; aluOut = 0;
        zeroFlag = 0; overflow = 0;
    endtask

    initial begin
        logic [31:0] prevSig;
        reset = 1; sampleLimit = 0;
        idleInputs();
        mA = '{default: 0};
        mB = '{default: 0};
        cycle(); cycle();

        // Reset state
        chk("rst.sigB", sigB, 32'hFFFFFFFF);
        chk("rst.sigA", sigA, 32'h0);
        chk("rst.busy", 32'(busyB), 32'h0);
        chk("rst.done", 32'(doneB), 32'h0);
        chk("rst.sc",   32'(scB), 32'h0);
        chk("rst.zc",   32'(zcA), 32'h0);
        chk("rst.oc",   32'(ocA), 32'h0);
        reset = 0;
        cycle();

        //          st sp lim   v ctrl a             z ov  eb ed sig           sc zc oc
        tbl[0]  = mk(1, 0, 16'd0, 0, 4'd0, 32'h0,        0, 0, 1, 0, 32'h0,        0, 0, 0);
        tbl[1]  = mk(0, 0, 16'd0, 1, 4'd0, 32'h0000000A, 0, 0, 1, 0, 32'h0A,       1, 0, 0);
        tbl[2]  = mk(0, 0, 16'd0, 1, 4'd1, 32'h0,        1, 0, 1, 0, 32'h11,       2, 1, 0);
        tbl[3]  = mk(0, 1, 16'd0, 0, 4'd0, 32'h0,        0, 0, 0, 1, 32'h11,       2, 1, 0);
        tbl[4]  = mk(0, 1, 16'd0, 1, 4'd7, 32'hFF,       1, 1, 0, 1, 32'h11,       2, 1, 0);
        tbl[5]  = mk(1, 0, 16'd3, 0, 4'd0, 32'h0,        0, 0, 1, 0, 32'h0,        0, 0, 0);
        tbl[6]  = mk(0, 0, 16'd0, 1, 4'd0, 32'h1,        0, 0, 1, 0, 32'h1,        1, 0, 0);
        tbl[7]  = mk(0, 0, 16'd0, 1, 4'd0, 32'h2,        0, 0, 1, 0, 32'h0,        2, 0, 0);
        tbl[8]  = mk(0, 0, 16'd0, 1, 4'd0, 32'h3,        0, 0, 0, 1, 32'h3,        3, 0, 0);
        tbl[9]  = mk(0, 0, 16'd0, 1, 4'd0, 32'h4,        0, 0, 0, 1, 32'h3,        3, 0, 0);
        tbl[10] = mk(0, 0, 16'd0, 1, 4'd0, 32'h5,        1, 1, 0, 1, 32'h3,        3, 0, 0);
        tbl[11] = mk(1, 1, 16'd0, 0, 4'd0, 32'h0,        0, 0, 1, 0, 32'h0,        0, 0, 0);
        tbl[12] = mk(0, 0, 16'd0, 1, 4'd0, 32'h8,        1, 0, 1, 0, 32'h9,        1, 1, 0);
        tbl[13] = mk(1, 0, 16'd0, 0, 4'd0, 32'h0,        0, 0, 1, 0, 32'h9,        1, 1, 0);
        tbl[14] = mk(0, 0, 16'd0, 1, 4'd0, 32'h0,        0, 1, 1, 0, 32'h10,       2, 1, 1);
        tbl[15] = mk(0, 1, 16'd0, 1, 4'd0, 32'h1,        0, 0, 0, 1, 32'h21,       3, 1, 1);

        for (int i = 0; i < 16; i++) begin
            start = tbl[i].st; stop = tbl[i].sp; sampleLimit = tbl[i].lim;
            sampleValid = tbl[i].v; aluControl = tbl[i].ctrl; aluOut = tbl[i].a;
            zeroFlag = tbl[i].z; overflow = tbl[i].ov;
            cycle();
            chk($sformatf("tbl%0d.busy", i), 32'(busyA), 32'(tbl[i].eb));
            chk($sformatf("tbl%0d.done", i), 32'(doneA), 32'(tbl[i].ed));
            chk($sformatf("tbl%0d.sig", i),  sigA, tbl[i].es);
            chk($sformatf("tbl%0d.sc", i),   32'(scA), 32'(tbl[i].esc));
            chk($sformatf("tbl%0d.zc", i),   32'(zcA), 32'(tbl[i].ezc));
            chk($sformatf("tbl%0d.oc", i),   32'(ocA), 32'(tbl[i].eoc));
            checkModel();
        end

        // Counter saturation on the 4-bit instance
        idleInputs(); sampleLimit = 0; start = 1;
        cycle();
        start = 0; sampleValid = 1; aluOut = 32'hFFFFFFFF; overflow = 1;
        prevSig = sigB;
        for (int i = 0; i < 20; i++) begin
            prevSig = sigB;
            cycle();
            checkModel();
        end
        chk("sat.scB", 32'(scB), 32'd15);
        chk("sat.ocB", 32'(ocB), 32'd15);
        chk("sat.scA", 32'(scA), 32'd20);
        chk("sat.sigMoves", 32'(sigB != prevSig), 32'h1);
        idleInputs(); stop = 1;
        cycle();
        checkModel();

        // Reset mid-run discards partial results
        idleInputs(); start = 1;
        cycle();
        start = 0; sampleValid = 1; aluOut = 32'h1234; zeroFlag = 1;
        cycle(); cycle();
        chk("midrun.scA", 32'(scA), 32'd2);
        reset = 1;
        cycle();
        reset = 0; idleInputs();
        chk("rst2.busy", 32'(busyA), 32'h0);
        chk("rst2.done", 32'(doneA), 32'h0);
        chk("rst2.sigA", sigA, 32'h0);
        chk("rst2.sigB", sigB, 32'hFFFFFFFF);
        chk("rst2.sc",   32'(scA), 32'h0);
        chk("rst2.zc",   32'(zcA), 32'h0);

        // Randomized stimulus against the model
        for (int i = 0; i < 600; i++) begin
            reset       = ($urandom_range(0, 63) == 0);
            start       = ($urandom_range(0, 7) == 0);
            stop        = ($urandom_range(0, 15) == 0);
            sampleValid = ($urandom_range(0, 3) != 0);
            sampleLimit = 16'($urandom_range(0, 6));
            aluControl  = 4'($urandom);
            aluOut      = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            zeroFlag    = 1'($urandom);
            overflow    = 1'($urandom);
            cycle();
            checkModel();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
